// File: rtl/interrupt_sequencer.sv
// Arbitrates ext/timer/soft machine interrupts into one registered one-hot request for execute.
// Optional build macro INT_SYNC_EN adds a 2-flop synchronizer on i_int_ext.
module interrupt_sequencer #(
  parameter int unsigned HOLDOFF_CYCLES = 2,
  parameter int unsigned CAUSE_W        = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_int_ext,
  input  logic               i_int_timer,
  input  logic               i_int_soft,
  input  logic [2:0]         i_mie,
  input  logic               i_gie,
  input  logic               i_stall,
  input  logic               i_ack,
  input  logic               i_flush,
  output logic               o_int_ext,
  output logic               o_int_timer,
  output logic               o_int_soft,
  output logic [CAUSE_W-1:0] o_cause,
  output logic [2:0]         o_pending,
  output logic               o_busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] TAKEN   = 2'd2;
  localparam logic [1:0] HOLDOFF = 2'd3;

  localparam int unsigned CNT_W = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

  localparam logic [CAUSE_W-1:0] CAUSE_EXT   = CAUSE_W'(11);
  localparam logic [CAUSE_W-1:0] CAUSE_TIMER = CAUSE_W'(7);
  localparam logic [CAUSE_W-1:0] CAUSE_SOFT  = CAUSE_W'(3);

  logic [1:0]         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]         r_req, w_req_nxt;
  logic [CAUSE_W-1:0] r_cause, w_cause_nxt;
  logic [1:0]         r_pend_ts;
  logic               w_ext_line;
  logic               w_pend_ext;
  logic [2:0]         w_eligible;
  logic [2:0]         w_win;
  logic [CAUSE_W-1:0] w_win_cause;
  logic               w_any;

`ifdef INT_SYNC_EN
  logic r_ext_s1, r_ext_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ext_s1 <= 1'b0;
      r_ext_s2 <= 1'b0;
    end else begin
      r_ext_s1 <= i_int_ext;
      r_ext_s2 <= r_ext_s1;
    end
  end

  // The second sync flop already serves as the registered pending bit.
  assign w_ext_line = r_ext_s2;
  assign w_pend_ext = r_ext_s2;
`else
  logic r_pend_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_ext <= 1'b0;
    end else begin
      r_pend_ext <= i_int_ext;
    end
  end

  assign w_ext_line = i_int_ext;
  assign w_pend_ext = r_pend_ext;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_ts <= 2'b00;
    end else begin
      r_pend_ts <= {i_int_timer, i_int_soft};
    end
  end

  assign w_eligible = {w_ext_line, i_int_timer, i_int_soft} & i_mie & {3{i_gie}};
  assign w_any      = |w_eligible;

  // Priority ext > soft > timer; bit order is {ext, timer, soft}.
  always_comb begin
    w_win       = 3'b000;
    w_win_cause = '0;
    if (w_eligible[2]) begin
      w_win       = 3'b100;
      w_win_cause = CAUSE_EXT;
    end else if (w_eligible[0]) begin
      w_win       = 3'b001;
      w_win_cause = CAUSE_SOFT;
    end else if (w_eligible[1]) begin
      w_win       = 3'b010;
      w_win_cause = CAUSE_TIMER;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_cause_nxt = r_cause;
    case (r_state)
      IDLE: begin
        if (w_any && !i_stall) begin
          w_state_nxt = REQ;
          w_req_nxt   = w_win;
          w_cause_nxt = w_win_cause;
        end
      end
      REQ: begin
        // Stall freezes the request; otherwise ack wins over any flush.
        if (!i_stall) begin
          if (i_ack) begin
            w_state_nxt = TAKEN;
            w_req_nxt   = 3'b000;
            w_cause_nxt = '0;
          end else if (w_any) begin
            w_req_nxt   = w_win;
            w_cause_nxt = w_win_cause;
          end else begin
            w_state_nxt = IDLE;
            w_req_nxt   = 3'b000;
            w_cause_nxt = '0;
          end
        end
      end
      TAKEN: begin
        if (i_flush) begin
          if (HOLDOFF_CYCLES == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = HOLDOFF;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      HOLDOFF: begin
        // Final holdoff cycle arbitrates like IDLE so the request lands right after holdoff.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_any && !i_stall) begin
          w_state_nxt = REQ;
          w_req_nxt   = w_win;
          w_cause_nxt = w_win_cause;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_req_nxt   = 3'b000;
        w_cause_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 3'b000;
      r_cause <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  assign o_int_ext   = r_req[2];
  assign o_int_timer = r_req[1];
  assign o_int_soft  = r_req[0];
  assign o_cause     = r_cause;
  assign o_pending   = {w_pend_ext, r_pend_ts};
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer (default HOLDOFF_CYCLES=2, CAUSE_W=4).
module tb_interrupt_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_int_ext, i_int_timer, i_int_soft;
  logic [2:0] i_mie;
  logic       i_gie, i_stall, i_ack, i_flush;
  logic       o_int_ext, o_int_timer, o_int_soft;
  logic [3:0] o_cause;
  logic [2:0] o_pending;
  logic       o_busy;

  int vectors     = 0;
  int miscompares = 0;

  interrupt_sequencer #(
    .HOLDOFF_CYCLES(2),
    .CAUSE_W       (4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_int_ext  (i_int_ext),
    .i_int_timer(i_int_timer),
    .i_int_soft (i_int_soft),
    .i_mie      (i_mie),
    .i_gie      (i_gie),
    .i_stall    (i_stall),
    .i_ack      (i_ack),
    .i_flush    (i_flush),
    .o_int_ext  (o_int_ext),
    .o_int_timer(o_int_timer),
    .o_int_soft (o_int_soft),
    .o_cause    (o_cause),
    .o_pending  (o_pending),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request vector packed as {ext, timer, soft, cause[3:0], busy}.
  task automatic check_req(input string tag, input logic [2:0] req, input logic [3:0] cause,
                           input logic busy);
    check(tag, {24'd0, o_int_ext, o_int_timer, o_int_soft, o_cause, o_busy},
          {24'd0, req, cause, busy});
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_int_ext = 0; i_int_timer = 0; i_int_soft = 0;
    i_mie = 3'b111; i_gie = 0; i_stall = 0; i_ack = 0; i_flush = 0;
    #1;
    check_req("reset_outputs", 3'b000, 4'd0, 1'b0);
    check("reset_pending", {29'd0, o_pending}, 32'd0);
    step();
    i_rst_n = 1'b1;
    step();
    check_req("idle_after_reset", 3'b000, 4'd0, 1'b0);

    // Timer request, ack, flush, holdoff, re-request
    i_gie = 1; i_int_timer = 1;
    step();
    check_req("timer_req", 3'b010, 4'd7, 1'b1);
    check("pending_timer", {29'd0, o_pending}, 32'd2);
    step();
    check_req("timer_held", 3'b010, 4'd7, 1'b1);
    i_ack = 1;
    step();
    i_ack = 0;
    check_req("taken_cleared", 3'b000, 4'd0, 1'b1);
    step();
    check_req("taken_wait_flush", 3'b000, 4'd0, 1'b1);
    i_flush = 1;
    step();
    i_flush = 0;
    check_req("holdoff_1", 3'b000, 4'd0, 1'b1);
    step();
    check_req("holdoff_0", 3'b000, 4'd0, 1'b1);
    step();
    check_req("rereq_timer", 3'b010, 4'd7, 1'b1);

    // Preemption: soft over timer, then ext over soft
    i_int_soft = 1;
    step();
    check_req("switch_soft", 3'b001, 4'd3, 1'b1);
    i_int_ext = 1;
    step();
    check_req("switch_ext", 3'b100, 4'd11, 1'b1);
    check("pending_all", {29'd0, o_pending}, 32'd7);

    // Stall freezes request even when all sources drop
    i_stall = 1;
    step();
    i_int_ext = 0; i_int_timer = 0; i_int_soft = 0;
    step();
    check_req("stall_hold_a", 3'b100, 4'd11, 1'b1);
    step();
    check_req("stall_hold_b", 3'b100, 4'd11, 1'b1);
    i_stall = 0;
    step();
    check_req("withdraw_idle", 3'b000, 4'd0, 1'b0);

    // Simultaneous ack+flush: a second flush is still needed
    i_int_timer = 1;
    step();
    check_req("timer_req2", 3'b010, 4'd7, 1'b1);
    i_ack = 1; i_flush = 1;
    step();
    i_ack = 0; i_flush = 0;
    check_req("ackflush_taken", 3'b000, 4'd0, 1'b1);
    step();
    step();
    check_req("still_taken", 3'b000, 4'd0, 1'b1);
    i_flush = 1;
    step();
    i_flush = 0;
    check_req("second_flush_hold", 3'b000, 4'd0, 1'b1);
    step();
    check_req("second_hold_0", 3'b000, 4'd0, 1'b1);
    step();
    check_req("rereq_timer2", 3'b010, 4'd7, 1'b1);

    // Global enable drop withdraws
    i_gie = 0;
    step();
    check_req("gie_drop", 3'b000, 4'd0, 1'b0);

    // Eligible under stall stays IDLE
    i_gie = 1; i_stall = 1;
    step();
    check_req("idle_stall", 3'b000, 4'd0, 1'b0);
    i_stall = 0;
    step();
    check_req("idle_unstall", 3'b010, 4'd7, 1'b1);

    // Flush without ack keeps request; masked ext does not preempt
    i_flush = 1; i_mie = 3'b011; i_int_ext = 1;
    step();
    i_flush = 0;
    check_req("flush_no_ack", 3'b010, 4'd7, 1'b1);

    // Async reset mid-REQ
    #2;
    i_rst_n = 1'b0;
    #1;
    check_req("async_reset", 3'b000, 4'd0, 1'b0);
    check("async_reset_pend", {29'd0, o_pending}, 32'd0);
    i_int_timer = 0; i_int_ext = 0; i_mie = 3'b111;
    step();
    i_rst_n = 1'b1;
    step();

    // Ext latency
    i_int_ext = 1;
`ifdef INT_SYNC_EN
    step();
    check_req("ext_sync_c1", 3'b000, 4'd0, 1'b0);
    check("ext_sync_pend_c1", {29'd0, o_pending}, 32'd0);
    step();
    check("ext_sync_pend_c2", {29'd0, o_pending}, 32'd4);
    check_req("ext_sync_c2", 3'b000, 4'd0, 1'b0);
    step();
    check_req("ext_sync_c3", 3'b100, 4'd11, 1'b1);
`else
    step();
    check_req("ext_direct", 3'b100, 4'd11, 1'b1);
    check("ext_direct_pend", {29'd0, o_pending}, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
